// File: rtl/mips_mux_pkg.sv
// rtl/mips_mux_pkg.sv - shared constants and helpers for the mux_arb_pipe family
package mips_mux_pkg;

   localparam int MODE_SELECT = 0;
   localparam int MODE_RR     = 1;

   // Index width that never collapses to zero bits (a 1-channel mux still needs a 1-bit index).
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with pointer look-ahead
//
// Ports:
//   req       in   CH    request vector
//   ptr       in   SELW  highest-priority index for this cycle
//   en        in   1     when low, nothing is granted
//   grant     out  CH    one-hot or zero grant
//   grant_idx out  SELW  index of the granted request (0 when none)
//   next_ptr  out  SELW  (grant_idx + 1) mod CH, or ptr when nothing is granted
module rr_arbiter
   import mips_mux_pkg::*;
#(
   parameter int CH   = 4,
   parameter int SELW = clog2_min1(CH)
) (
   input  logic [CH-1:0]   req,
   input  logic [SELW-1:0] ptr,
   input  logic            en,
   output logic [CH-1:0]   grant,
   output logic [SELW-1:0] grant_idx,
   output logic [SELW-1:0] next_ptr
);

   int   idx;
   logic found;

   // Walk the channels starting at ptr; the first requester wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      next_ptr  = ptr;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < CH; k++) begin
         idx = (int'(ptr) + k) % CH;
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = SELW'(idx);
            next_ptr   = SELW'((idx + 1) % CH);
         end
      end
   end

endmodule

// File: rtl/mux_arb_pipe.sv
// rtl/mux_arb_pipe.sv - CH-input N-bit mux with valid/ready and one registered output stage
//
// Ports:
//   clk        in   1      clock
//   rst_n      in   1      synchronous active-low reset
//   in_data    in   CH*N   packed channel data, channel i at [i*N +: N]
//   in_valid   in   CH     per-channel valid
//   in_ready   out  CH     per-channel ready (combinational)
//   sel        in   SELW   channel select (SELECT mode only)
//   out_data   out  N      registered data
//   out_ch     out  SELW   channel that supplied out_data
//   out_valid  out  1      registered valid
//   out_ready  in   1      downstream ready
module mux_arb_pipe
   import mips_mux_pkg::*;
#(
   parameter  int N    = 32,
   parameter  int CH   = 4,
   parameter  int MODE = 0,
   localparam int SELW = clog2_min1(CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH*N-1:0] in_data,
   input  logic [CH-1:0]   in_valid,
   output logic [CH-1:0]   in_ready,
   input  logic [SELW-1:0] sel,
   output logic [N-1:0]    out_data,
   output logic [SELW-1:0] out_ch,
   output logic            out_valid,
   input  logic            out_ready
);

   logic            load;
   logic            fire;
   logic [CH-1:0]   grant;
   logic [SELW-1:0] gidx;
   logic [N-1:0]    mux_data;

   // The output register can take a word when it is empty or being drained this cycle.
   assign load     = ~out_valid | out_ready;
   assign in_ready = rst_n ? (grant & {CH{load}}) : '0;
   assign fire     = |(in_valid & in_ready);

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic [SELW-1:0] rr_ptr;
         logic [SELW-1:0] next_ptr;
         logic [SELW-1:0] arb_idx;

         rr_arbiter #(.CH(CH), .SELW(SELW)) u_arb (
            .req       (in_valid),
            .ptr       (rr_ptr),
            .en        (load),
            .grant     (grant),
            .grant_idx (arb_idx),
            .next_ptr  (next_ptr)
         );

         assign gidx = arb_idx;

         // Pointer moves only on an accepted word, so stalls keep the fairness order.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rr_ptr <= '0;
            end else if (fire) begin
               rr_ptr <= next_ptr;
            end
         end
      end else if (CH == 1) begin : g_single
         assign grant = in_valid;
         assign gidx  = '0;
      end else begin : g_sel
         // An out-of-range sel matches no channel and therefore grants nothing.
         for (genvar i = 0; i < CH; i++) begin : g_cmp
            assign grant[i] = (sel == SELW'(i)) & in_valid[i];
         end
         assign gidx = sel;
      end
   endgenerate

   // AND-OR mux keyed by the one-hot grant; avoids indexing with an out-of-range sel.
   always_comb begin
      mux_data = '0;
      for (int i = 0; i < CH; i++) begin
         if (grant[i]) begin
            mux_data = mux_data | in_data[i*N +: N];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load) begin
         out_valid <= fire;
         if (fire) begin
            out_data <= mux_data;
            out_ch   <= gidx;
         end
      end
   end

endmodule
